// File: rtl/execute_alu_imm_issue_arb_pkg.sv
// Shared definitions for the ALU immediate-operand issue arbiter.
// Holds the operand-mode encodings, the structural constants and the
// operand formatting function. Any block that needs the encodings imports
// this package.
package execute_alu_imm_issue_arb_pkg;

  typedef enum logic [1:0] {
    ALU_IMPL_LUT6OPT_BYPASS   = 2'd0,
    ALU_IMPL_LUT6OPT_IMM_ZEXT = 2'd1,
    ALU_IMPL_LUT6OPT_IMM_SEXT = 2'd2,
    ALU_IMPL_LUT6OPT_LUI      = 2'd3
  } alu_imm_sel_e;

  localparam int ALU_IMM_ARB_PORT_W = 1;
  localparam int ALU_IMM_FIFO_DEPTH = 2;
  localparam int ALU_IMM_TAG_W      = 4;

  // Immediate-operand unit: one 4:1 choice per output bit, which maps onto
  // a single LUT6 level.
  function automatic logic [31:0] alu_imm_format(input logic [1:0]  sel,
                                                 input logic [31:0] d0,
                                                 input logic [15:0] d1);
    logic [31:0] res;
    case (alu_imm_sel_e'(sel))
      ALU_IMPL_LUT6OPT_IMM_ZEXT: res = {16'h0000, d1};
      ALU_IMPL_LUT6OPT_IMM_SEXT: res = {{16{d1[15]}}, d1};
      ALU_IMPL_LUT6OPT_LUI:      res = {d1, 16'h0000};
      default:                   res = d0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/execute_alu_imm_issue_arb_if.sv
// Bundle of the two issue-port request handshakes and the result-FIFO
// output handshake.
//   i0_* / i1_* : valid, ready, d0 (register operand), d1 (immediate),
//                 sel (operand mode), tag (ROB index)
//   out_*       : valid, ready, data (formatted operand), tag, src port
// master = issue queues + ALU side, slave = the arbiter.
interface execute_alu_imm_issue_arb_if
  import execute_alu_imm_issue_arb_pkg::*;
#(
  parameter int TAG_W = ALU_IMM_TAG_W
);
  logic             i0_valid, i0_ready;
  logic [31:0]      i0_d0;
  logic [15:0]      i0_d1;
  logic [1:0]       i0_sel;
  logic [TAG_W-1:0] i0_tag;

  logic             i1_valid, i1_ready;
  logic [31:0]      i1_d0;
  logic [15:0]      i1_d1;
  logic [1:0]       i1_sel;
  logic [TAG_W-1:0] i1_tag;

  logic             out_valid, out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_src;

  modport master (
    output i0_valid, i0_d0, i0_d1, i0_sel, i0_tag,
    input  i0_ready,
    output i1_valid, i1_d0, i1_d1, i1_sel, i1_tag,
    input  i1_ready,
    input  out_valid, out_data, out_tag, out_src,
    output out_ready
  );

  modport slave (
    input  i0_valid, i0_d0, i0_d1, i0_sel, i0_tag,
    output i0_ready,
    input  i1_valid, i1_d0, i1_d1, i1_sel, i1_tag,
    output i1_ready,
    output out_valid, out_data, out_tag, out_src,
    input  out_ready
  );
endinterface

// File: rtl/execute_alu_imm_issue_arb_rr2.sv
// Two-way round-robin picker.
//   clk, resetn : clock, async active-low reset
//   req[1:0]    : request per port
//   accept      : the granted request transferred this cycle
//   grant[1:0]  : one-hot (or zero) grant, purely combinational on req
// rr names the preferred port on a tie; it moves to the loser only when a
// grant is actually accepted, so a stalled winner keeps its grant.
module execute_alu_imm_rr2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);
  logic rr;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr <= 1'b0;
    end else if (accept) begin
      rr <= ~grant[1];
    end
  end
endmodule

// File: rtl/execute_alu_imm_issue_arb.sv
// Shares one immediate-operand unit between two ALU issue ports.
//   clk, resetn : clock, async active-low reset
//   flush       : synchronous pipeline flush (empties the FIFO)
//   bus         : issue-port requests in, formatted operands out
// The round-robin winner is formatted and pushed into a 2-entry FIFO that
// feeds the ALU operand-B mux.
module execute_alu_imm_issue_arb
  import execute_alu_imm_issue_arb_pkg::*;
#(
  parameter int TAG_W = ALU_IMM_TAG_W
) (
  input  logic clk,
  input  logic resetn,
  input  logic flush,
  execute_alu_imm_issue_arb_if.slave bus
);
  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             src;
  } entry_t;

  entry_t     mem [ALU_IMM_FIFO_DEPTH];
  entry_t     push_entry;
  entry_t     head;
  logic [1:0] count;
  logic       rd_ptr, wr_ptr;
  logic       space, push, pop, winner;
  logic [1:0] grant;
  logic [1:0] win_sel;
  logic [31:0] win_d0;
  logic [15:0] win_d1;

  // Space looks only at the registered count, so ready never depends on
  // out_ready; a full FIFO costs one input bubble while it drains.
  assign space = resetn & (count < 2'd2) & ~flush;

  execute_alu_imm_rr2 u_rr (
    .clk    (clk),
    .resetn (resetn),
    .req    ({bus.i1_valid, bus.i0_valid}),
    .accept (push),
    .grant  (grant)
  );

  assign bus.i0_ready = grant[0] & space;
  assign bus.i1_ready = grant[1] & space;
  assign push   = (bus.i0_valid & bus.i0_ready) | (bus.i1_valid & bus.i1_ready);
  assign winner = grant[1];
  assign pop    = (count != 2'd0) & bus.out_ready & ~flush;

  // Operand mux ahead of the single shared formatting unit.
  always_comb begin
    win_sel = bus.i0_sel;
    win_d0  = bus.i0_d0;
    win_d1  = bus.i0_d1;
    push_entry.tag = bus.i0_tag;
    if (winner) begin
      win_sel = bus.i1_sel;
      win_d0  = bus.i1_d0;
      win_d1  = bus.i1_d1;
      push_entry.tag = bus.i1_tag;
    end
    push_entry.data = alu_imm_format(win_sel, win_d0, win_d1);
    push_entry.src  = winner;
  end

  // FIFO storage and pointers. Flush drops everything and discards any
  // handshake seen in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < ALU_IMM_FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Outputs read as zero whenever the FIFO is empty.
  assign head          = mem[rd_ptr];
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = bus.out_valid ? head.data : 32'h0;
  assign bus.out_tag   = bus.out_valid ? head.tag  : '0;
  assign bus.out_src   = bus.out_valid & head.src;
endmodule

// File: tb/tb_execute_alu_imm_issue_arb.sv
// Self-checking bench for execute_alu_imm_issue_arb: a cycle model of the
// arbiter and a scoreboard queue of expected FIFO entries.
module tb_execute_alu_imm_issue_arb;
  logic clk = 1'b0;
  logic resetn;
  logic flush;
  int   compared   = 0;
  int   mismatched = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        src;
  } exp_t;

  exp_t sb[$];
  bit   m_rr;

  execute_alu_imm_issue_arb_if #(.TAG_W(4)) bus ();

  execute_alu_imm_issue_arb #(.TAG_W(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_fmt(input int sel, input logic [31:0] d0,
                                          input logic [15:0] d1);
    case (sel)
      1:       return {16'h0000, d1};
      2:       return {{16{d1[15]}}, d1};
      3:       return {d1, 16'h0000};
      default: return d0;
    endcase
  endfunction

  // Structural invariants: count never exceeds depth, never pops empty.
  always @(negedge clk) begin
    #2;
    if (resetn === 1'b1) begin
      if (dut.count > 2'd2) begin
        mismatched++;
        $display("[TB] FAIL overflow count=%0d limit=2", dut.count);
      end
      if (dut.pop && dut.count == 2'd0) begin
        mismatched++;
        $display("[TB] FAIL underflow pop with count=0 required no pop");
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout simulation did not finish required finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic set_port(input int k, input bit v, input int sel,
                          input logic [31:0] d0, input logic [15:0] d1,
                          input logic [3:0] tag);
    if (k == 0) begin
      bus.i0_valid = v; bus.i0_sel = sel[1:0]; bus.i0_d0 = d0;
      bus.i0_d1 = d1; bus.i0_tag = tag;
    end else begin
      bus.i1_valid = v; bus.i1_sel = sel[1:0]; bus.i1_d0 = d0;
      bus.i1_d1 = d1; bus.i1_tag = tag;
    end
  endtask

  // One clock: check ready/head against the model, then advance the model.
  task automatic cycle();
    bit   g0, g1, sp, pop, r0, r1;
    exp_t e;
    #1;
    sp = resetn && (sb.size() < 2) && !flush;
    g0 = bus.i0_valid && (!bus.i1_valid || !m_rr);
    g1 = bus.i1_valid && (!bus.i0_valid || m_rr);
    r0 = g0 && sp;
    r1 = g1 && sp;
    compared++;
    if (bus.i0_ready !== r0) begin
      mismatched++; $display("[TB] FAIL i0_ready got %b want %b", bus.i0_ready, r0);
    end
    compared++;
    if (bus.i1_ready !== r1) begin
      mismatched++; $display("[TB] FAIL i1_ready got %b want %b", bus.i1_ready, r1);
    end
    compared++;
    if (bus.out_valid !== (sb.size() != 0)) begin
      mismatched++;
      $display("[TB] FAIL out_valid got %b want %b", bus.out_valid, sb.size() != 0);
    end
    if (sb.size() != 0) begin
      compared++;
      if (bus.out_data !== sb[0].data || bus.out_tag !== sb[0].tag ||
          bus.out_src !== sb[0].src) begin
        mismatched++;
        $display("[TB] FAIL head got %h/%h/%b want %h/%h/%b", bus.out_data,
                 bus.out_tag, bus.out_src, sb[0].data, sb[0].tag, sb[0].src);
      end
    end
    pop = (sb.size() != 0) && bus.out_ready && !flush;
    if (r1) e = '{exp_fmt(bus.i1_sel, bus.i1_d0, bus.i1_d1), bus.i1_tag, 1'b1};
    else    e = '{exp_fmt(bus.i0_sel, bus.i0_d0, bus.i0_d1), bus.i0_tag, 1'b0};
    @(posedge clk);
    if (flush) sb.delete();
    else begin
      if (pop) void'(sb.pop_front());
      if (r0 || r1) begin
        sb.push_back(e);
        m_rr = r1 ? 1'b0 : 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_ports();
    set_port(0, 0, 0, 32'h0, 16'h0, 4'h0);
    set_port(1, 0, 0, 32'h0, 16'h0, 4'h0);
  endtask

  task automatic drain();
    idle_ports();
    bus.out_ready = 1'b1;
    repeat (3) cycle();
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; bus.out_ready = 1'b0;
    set_port(0, 1, 0, 32'h11111111, 16'h0, 4'h1);
    set_port(1, 1, 0, 32'h22222222, 16'h0, 4'h2);
    repeat (2) @(negedge clk);
    #1;
    compared++;
    if (bus.i0_ready !== 1'b0 || bus.i1_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ready got %b%b want 00", bus.i1_ready, bus.i0_ready);
    end
    compared++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_tag !== 4'h0 ||
        bus.out_src !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_out got %b/%h/%h/%b want 0/0/0/0", bus.out_valid,
               bus.out_data, bus.out_tag, bus.out_src);
    end
    sb.delete(); m_rr = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    cycle();
    drain();
  endtask

  task automatic test_format();
    int          sel [4]  = '{2, 3, 1, 0};
    logic [31:0] d0  [4]  = '{32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
    logic [15:0] d1  [4]  = '{16'h8001, 16'h1234, 16'h8001, 16'h5555};
    logic [31:0] want [4] = '{32'hFFFF8001, 32'h12340000, 32'h00008001, 32'hDEADBEEF};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_port(0, 1, sel[k], d0[k], d1[k], 4'(k + 3));
      set_port(1, 0, 0, 32'h0, 16'h0, 4'h0);
      cycle();
      idle_ports();
      #1;
      compared++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== want[k] || bus.out_src !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL format_%0d got %b/%h/%b want 1/%h/0", k, bus.out_valid,
                 bus.out_data, bus.out_src, want[k]);
      end
      cycle();
    end
  endtask

  task automatic test_fairness();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_port(0, 1, 1, 32'h0, 16'(16'h0100 + k), 4'(k));
      set_port(1, 1, 3, 32'h0, 16'(16'h0200 + k), 4'(k + 8));
      cycle();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_port(0, 1, 0, 32'(32'hA000 + k), 16'h0, 4'(k + 1));
      set_port(1, 0, 0, 32'h0, 16'h0, 4'h0);
      cycle();
    end
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    cycle();
    drain();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    set_port(0, 1, 2, 32'h0, 16'hF00F, 4'h5);
    set_port(1, 1, 3, 32'h0, 16'h0F0F, 4'h6);
    repeat (2) cycle();
    flush = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    flush = 1'b0;
    idle_ports();
    cycle();
    #1;
    compared++;
    if (dut.count !== 2'd0) begin
      mismatched++; $display("[TB] FAIL flush_count got %0d want 0", dut.count);
    end
    drain();
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    set_port(0, 1, 0, 32'hCAFE0000, 16'h0, 4'h7);
    set_port(1, 1, 0, 32'hCAFE0001, 16'h0, 4'h8);
    repeat (2) cycle();
    #2;
    resetn = 1'b0;
    #1;
    compared++;
    if (bus.out_valid !== 1'b0 || bus.i0_ready !== 1'b0 || bus.i1_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL async_reset got valid=%b ready=%b%b want 0 00", bus.out_valid,
               bus.i1_ready, bus.i0_ready);
    end
    sb.delete(); m_rr = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    cycle();
    drain();
  endtask

  initial begin
    idle_ports();
    test_reset();
    test_format();
    test_fairness();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
